// File: rtl/commands_encoder_pkg.sv
// rtl/commands_encoder_pkg.sv - shared types and byte constants for the VT100/ANSI command encoder
//
// Purpose: command and state enums plus the fixed sequence bytes used by
//          commands_encoder and its testbench.
// Ports:   none (package).

package commands_encoder_pkg;

  typedef enum logic [2:0] {
    ENC_CHAR = 3'd0,
    ENC_CUU  = 3'd1,
    ENC_CUD  = 3'd2,
    ENC_CUF  = 3'd3,
    ENC_CUB  = 3'd4,
    ENC_CPR  = 3'd5,
    ENC_DA   = 3'd6
  } EncCmd_t;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CHAR  = 4'd1,
    ESC   = 4'd2,
    CSI   = 4'd3,
    QUES  = 4'd4,
    PN1   = 4'd5,
    DEL   = 4'd6,
    PN2   = 4'd7,
    FINAL = 4'd8
  } EncState_t;

  localparam logic [7:0] BYTE_ESC   = 8'h1B;
  localparam logic [7:0] BYTE_LBRKT = 8'h5B;
  localparam logic [7:0] BYTE_SEMI  = 8'h3B;
  localparam logic [7:0] BYTE_QUES  = 8'h3F;
  localparam logic [7:0] BYTE_ZERO  = 8'h30;

  localparam logic [7:0] FINAL_CUU  = 8'h41;
  localparam logic [7:0] FINAL_CUD  = 8'h42;
  localparam logic [7:0] FINAL_CUF  = 8'h43;
  localparam logic [7:0] FINAL_CUB  = 8'h44;
  localparam logic [7:0] FINAL_CPR  = 8'h52;
  localparam logic [7:0] FINAL_DA   = 8'h63;

  // Device-attribute reply carries the fixed parameters "1" and "0".
  localparam logic [7:0] DA_PARAM1  = 8'h31;
  localparam logic [7:0] DA_PARAM2  = 8'h30;

  function automatic logic [7:0] final_byte(input EncCmd_t t);
    logic [7:0] b;
    case (t)
      ENC_CUU: b = FINAL_CUU;
      ENC_CUD: b = FINAL_CUD;
      ENC_CUF: b = FINAL_CUF;
      ENC_CUB: b = FINAL_CUB;
      ENC_CPR: b = FINAL_CPR;
      ENC_DA:  b = FINAL_DA;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/commands_encoder_dec_digits.sv
// rtl/commands_encoder_dec_digits.sv - 8-bit binary to three BCD digits plus significant digit count
//
// Purpose: combinational double-dabble conversion used to print numeric
//          parameters as minimal decimal ASCII.
// Ports:   value    in  8  binary input (0-255)
//          hundreds out 4  BCD hundreds digit
//          tens     out 4  BCD tens digit
//          units    out 4  BCD units digit
//          count    out 2  number of significant digits (1-3)

module dec_digits (
  input  logic [7:0] value,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [1:0] count
);

  logic [19:0] shift;

  always_comb begin
    shift = {12'd0, value};
    for (int i = 0; i < 8; i++) begin
      if (shift[11:8]  >= 4'd5) shift[11:8]  = shift[11:8]  + 4'd3;
      if (shift[15:12] >= 4'd5) shift[15:12] = shift[15:12] + 4'd3;
      if (shift[19:16] >= 4'd5) shift[19:16] = shift[19:16] + 4'd3;
      shift = {shift[18:0], 1'b0};
    end
    hundreds = shift[19:16];
    tens     = shift[15:12];
    units    = shift[11:8];
  end

  always_comb begin
    if (value >= 8'd100)     count = 2'd3;
    else if (value >= 8'd10) count = 2'd2;
    else                     count = 2'd1;
  end

endmodule

// File: rtl/commands_encoder.sv
// rtl/commands_encoder.sv - serializes terminal commands into VT100/ANSI byte streams
//
// Purpose: accepts one command per handshake, emits its escape sequence one
//          byte per data handshake with numeric parameters as decimal ASCII.
// Config:  COMMANDS_ENCODER_OMIT_DEFAULT_EN - when defined, cursor moves with
//          Pn1 == 1 omit the parameter (ESC [ A instead of ESC [ 1 A).
// Ports:   clk       in  1  system clock
//          rst       in  1  asynchronous active-high reset
//          cmdValid  in  1  command offered
//          cmdReady  out 1  encoder idle, accepts command
//          cmdType   in  3  EncCmd_t command selector
//          cmdPchar  in  8  raw byte for ENC_CHAR
//          cmdPn1    in  8  first numeric parameter
//          cmdPn2    in  8  second numeric parameter (ENC_CPR)
//          data      out 8  output byte (registered)
//          dataValid out 1  data holds a byte (registered)
//          dataReady in  1  downstream accepts the byte
//          debug     out 8  current state encoding, zero-extended

module commands_encoder
  import commands_encoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  EncCmd_t    cmdType,
  input  logic [7:0] cmdPchar,
  input  logic [7:0] cmdPn1,
  input  logic [7:0] cmdPn2,
  output logic [7:0] data,
  output logic       dataValid,
  input  logic       dataReady,
  output logic [7:0] debug
);

  EncState_t  state, nxt_state;
  logic [1:0] idx, nxt_idx;
  EncCmd_t    type_q;
  logic [7:0] pchar_q, pn1_q, pn2_q;
  logic [7:0] nxt_data;

  logic       accept, xfer, is_da, is_cpr, skip_pn1;
  logic [7:0] dec_in;
  logic [3:0] dec_h, dec_t, dec_u, digit;
  logic [1:0] dec_cnt;

  assign cmdReady = (state == IDLE);
  assign accept   = cmdValid && cmdReady;
  assign xfer     = dataValid && dataReady;
  assign debug    = {4'd0, state};
  assign is_da    = (type_q == ENC_DA);
  assign is_cpr   = (type_q == ENC_CPR);

`ifdef COMMANDS_ENCODER_OMIT_DEFAULT_EN
  assign skip_pn1 = (type_q inside {ENC_CUU, ENC_CUD, ENC_CUF, ENC_CUB}) && (pn1_q == 8'd1);
`else
  assign skip_pn1 = 1'b0;
`endif

  // Next state depends only on the current state, handshakes and the
  // digit index, never on the decoder output, so the decoder input mux
  // below can safely follow nxt_state.
  always_comb begin
    nxt_state = state;
    unique case (state)
      IDLE:        if (cmdValid) nxt_state = (cmdType == ENC_CHAR) ? CHAR : ESC;
      CHAR, FINAL: if (xfer) nxt_state = IDLE;
      ESC:         if (xfer) nxt_state = CSI;
      CSI: begin
        if (xfer) begin
          if (is_da)         nxt_state = QUES;
          else if (skip_pn1) nxt_state = FINAL;
          else               nxt_state = PN1;
        end
      end
      QUES:        if (xfer) nxt_state = PN1;
      PN1:         if (xfer && idx == 2'd0) nxt_state = (is_cpr || is_da) ? DEL : FINAL;
      DEL:         if (xfer) nxt_state = PN2;
      PN2:         if (xfer && idx == 2'd0) nxt_state = FINAL;
      default:     nxt_state = IDLE;
    endcase
  end

  assign dec_in = (nxt_state == PN2) ? pn2_q : pn1_q;

  dec_digits u_dec_digits (
    .value    (dec_in),
    .hundreds (dec_h),
    .tens     (dec_t),
    .units    (dec_u),
    .count    (dec_cnt)
  );

  // Byte and digit index for the state being entered; registered only on
  // accept or transfer so the output holds through stalls.
  always_comb begin
    nxt_idx  = idx;
    nxt_data = 8'h00;
    digit    = dec_u;

    if (nxt_state == PN1 || nxt_state == PN2) begin
      if (nxt_state != state) nxt_idx = is_da ? 2'd0 : dec_cnt - 2'd1;
      else                    nxt_idx = idx - 2'd1;
    end

    case (nxt_idx)
      2'd2:    digit = dec_h;
      2'd1:    digit = dec_t;
      default: digit = dec_u;
    endcase

    unique case (nxt_state)
      IDLE:    nxt_data = 8'h00;
      CHAR:    nxt_data = (state == IDLE) ? cmdPchar : pchar_q;
      ESC:     nxt_data = BYTE_ESC;
      CSI:     nxt_data = BYTE_LBRKT;
      QUES:    nxt_data = BYTE_QUES;
      PN1:     nxt_data = is_da ? DA_PARAM1 : (BYTE_ZERO | {4'd0, digit});
      DEL:     nxt_data = BYTE_SEMI;
      PN2:     nxt_data = is_da ? DA_PARAM2 : (BYTE_ZERO | {4'd0, digit});
      FINAL:   nxt_data = final_byte(type_q);
      default: nxt_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      type_q    <= ENC_CHAR;
      pchar_q   <= 8'h00;
      pn1_q     <= 8'h00;
      pn2_q     <= 8'h00;
      data      <= 8'h00;
      dataValid <= 1'b0;
    end else begin
      state <= nxt_state;
      if (accept) begin
        type_q  <= cmdType;
        pchar_q <= cmdPchar;
        pn1_q   <= cmdPn1;
        pn2_q   <= cmdPn2;
      end
      if (accept || xfer) begin
        idx       <= nxt_idx;
        data      <= nxt_data;
        dataValid <= (nxt_state != IDLE);
      end
    end
  end

endmodule

// File: tb/tb_commands_encoder.sv
// tb/tb_commands_encoder.sv - self-checking bench for commands_encoder

module tb_commands_encoder;
  import commands_encoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmdValid;
  logic       cmdReady;
  EncCmd_t    cmdType;
  logic [7:0] cmdPchar, cmdPn1, cmdPn2;
  logic [7:0] data;
  logic       dataValid;
  logic       dataReady;
  logic [7:0] debug;

  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  commands_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .cmdValid  (cmdValid),
    .cmdReady  (cmdReady),
    .cmdType   (cmdType),
    .cmdPchar  (cmdPchar),
    .cmdPn1    (cmdPn1),
    .cmdPn2    (cmdPn2),
    .data      (data),
    .dataValid (dataValid),
    .dataReady (dataReady),
    .debug     (debug)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model: the expected byte stream written as the ANSI text itself.
  task automatic build_expected(input EncCmd_t t, input logic [7:0] pc, input logic [7:0] p1,
                                input logic [7:0] p2);
    string s;
    string finals;
    bit    omit;
    omit   = 1'b0;
    finals = "ABCD";
`ifdef COMMANDS_ENCODER_OMIT_DEFAULT_EN
    omit = 1'b1;
`endif
    exp_q.delete();
    s = "";
    case (t)
      ENC_CHAR: exp_q.push_back(pc);
      ENC_CUU, ENC_CUD, ENC_CUF, ENC_CUB: begin
        s = $sformatf("%c[", 8'h1B);
        if (!(omit && p1 == 8'd1)) s = {s, $sformatf("%0d", p1)};
        s = {s, finals.substr(int'(t) - 1, int'(t) - 1)};
      end
      ENC_CPR: s = $sformatf("%c[%0d;%0dR", 8'h1B, p1, p2);
      ENC_DA:  s = $sformatf("%c[?1;0c", 8'h1B);
      default: s = "";
    endcase
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic run_cmd(input string tag, input EncCmd_t t, input logic [7:0] pc,
                         input logic [7:0] p1, input logic [7:0] p2, input bit stall);
    int n, cyc, total;
    logic held_v;
    logic [7:0] held;
    build_expected(t, pc, p1, p2);
    total = exp_q.size();
    cyc = 0;
    while (!cmdReady && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check1({tag, "_idle_ready"}, cmdReady, 1'b1);
    cmdValid  = 1'b1;
    cmdType   = t;
    cmdPchar  = pc;
    cmdPn1    = p1;
    cmdPn2    = p2;
    dataReady = 1'b1;
    @(negedge clk);
    // Scramble the command inputs: the encoder must have latched them.
    cmdType  = EncCmd_t'(3'($urandom_range(0, 6)));
    cmdPchar = 8'($urandom_range(0, 255));
    cmdPn1   = 8'($urandom_range(0, 255));
    cmdPn2   = 8'($urandom_range(0, 255));
    n = 0;
    cyc = 0;
    held_v = 1'b0;
    held = 8'h00;
    while (exp_q.size() > 0 && cyc < 300) begin
      // Offer a junk command while busy; withdraw it before the last byte.
      cmdValid  = (exp_q.size() > 1);
      dataReady = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      check1({tag, "_valid"}, dataValid, 1'b1);
      check1({tag, "_busy"}, cmdReady, 1'b0);
      if (held_v) check8({tag, "_hold"}, data, held);
      if (dataReady) begin
        check8({tag, "_byte"}, data, exp_q.pop_front());
        n++;
        held_v = 1'b0;
      end else begin
        held_v = 1'b1;
        held = data;
      end
      @(negedge clk);
      cyc++;
    end
    cmdValid = 1'b0;
    check8({tag, "_count"}, 8'(n), 8'(total));
    check1({tag, "_end_valid"}, dataValid, 1'b0);
    check1({tag, "_end_ready"}, cmdReady, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    cmdValid  = 1'b0;
    cmdType   = ENC_CHAR;
    cmdPchar  = 8'h00;
    cmdPn1    = 8'h00;
    cmdPn2    = 8'h00;
    dataReady = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check1("reset_cmdReady", cmdReady, 1'b1);
    check1("reset_dataValid", dataValid, 1'b0);
    check8("reset_data", data, 8'h00);
    check8("reset_debug", debug, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    run_cmd("char41", ENC_CHAR, 8'h41, 8'd0, 8'd0, 1'b0);
    run_cmd("cuf12", ENC_CUF, 8'h00, 8'd12, 8'd0, 1'b0);
    run_cmd("cpr24_80", ENC_CPR, 8'h00, 8'd24, 8'd80, 1'b0);
    run_cmd("da", ENC_DA, 8'h00, 8'd77, 8'd99, 1'b0);
    run_cmd("cub255_stall", ENC_CUB, 8'h00, 8'd255, 8'd0, 1'b1);
    run_cmd("cuu1", ENC_CUU, 8'h00, 8'd1, 8'd0, 1'b0);
    run_cmd("cuu0", ENC_CUU, 8'h00, 8'd0, 8'd0, 1'b0);
    run_cmd("cud9", ENC_CUD, 8'h00, 8'd9, 8'd0, 1'b0);
    run_cmd("cud10", ENC_CUD, 8'h00, 8'd10, 8'd0, 1'b1);
    run_cmd("cud99", ENC_CUD, 8'h00, 8'd99, 8'd0, 1'b0);
    run_cmd("cud100", ENC_CUD, 8'h00, 8'd100, 8'd0, 1'b1);
    run_cmd("cpr0_255", ENC_CPR, 8'h00, 8'd0, 8'd255, 1'b1);
    run_cmd("char00", ENC_CHAR, 8'h00, 8'd5, 8'd5, 1'b0);

    // Reset after the third byte of a CPR aborts the sequence.
    build_expected(ENC_CPR, 8'h00, 8'd24, 8'd80);
    cmdValid  = 1'b1;
    cmdType   = ENC_CPR;
    cmdPn1    = 8'd24;
    cmdPn2    = 8'd80;
    dataReady = 1'b1;
    @(negedge clk);
    cmdValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check8("rstmid_byte", data, exp_q.pop_front());
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check1("rstmid_dataValid", dataValid, 1'b0);
    check1("rstmid_cmdReady", cmdReady, 1'b1);
    check8("rstmid_debug", debug, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_cmd("after_rst_char5A", ENC_CHAR, 8'h5A, 8'd0, 8'd0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      run_cmd("rand", EncCmd_t'(3'($urandom_range(0, 6))), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/commands_encoder.md
# commands_encoder

Serializes terminal-side commands into VT100/ANSI byte streams: raw characters, cursor-move sequences, cursor position reports, and device attribute replies. It is the transmit counterpart of the commands parser. It takes one command per handshake from the console controller or keyboard logic, converts its numeric parameters to decimal ASCII, and feeds bytes one at a time to the UART transmitter over a valid/ready handshake.

## Interface
- No parameters.
- Ports:
  - clk  in  1  system clock; all state updates on the rising edge.
  - rst  in  1  asynchronous, active-high reset.
  - cmdValid  in  1  a command is offered on cmdType/cmdPchar/cmdPn1/cmdPn2.
  - cmdReady  out  1  encoder is idle and accepts a command this cycle.
  - cmdType  in  EncCmd_t  ENC_CHAR, ENC_CUU, ENC_CUD, ENC_CUF, ENC_CUB, ENC_CPR, ENC_DA.
  - cmdPchar  in  8  raw byte for ENC_CHAR.
  - cmdPn1  in  8  first numeric parameter (unsigned, 0–255).
  - cmdPn2  in  8  second numeric parameter (ENC_CPR only).
  - data  out  8  output byte.
  - dataValid  out  1  data holds a byte to transfer.
  - dataReady  in  1  UART transmitter accepts the byte.
  - debug  out  8  current state encoding, zero-extended.

## Operation
- Command accept: cmdValid && cmdReady. On accept, type, Pchar, Pn1 and Pn2 are latched and later input changes are ignored.
- cmdReady = (state == IDLE).
- Byte transfer: dataValid && dataReady. After a transfer, the FSM advances.
- Emitted byte strings:
  - ENC_CHAR: Pchar.
  - ENC_CUU/CUD/CUF/CUB: 1B 5B dec(Pn1) then 41/42/43/44 respectively.
  - ENC_CPR: 1B 5B dec(Pn1) 3B dec(Pn2) 52.
  - ENC_DA: 1B 5B 3F 31 3B 30 63. These are fixed bytes; the latched Pn values are ignored.
- dec(v): minimal decimal ASCII with no leading zeros.
  - Hundreds digit only when v ≥ 100; tens digit only when v ≥ 10; units digit always.
  - dec(0) = 30.
  - Digits are 30 + BCD value.
- FSM states: IDLE, CHAR, ESC, CSI, QUES, PN1, DEL, PN2, FINAL.
  - IDLE → CHAR (ENC_CHAR) or ESC (all other types) on accept.
  - ESC → CSI.
  - CSI → QUES (DA), else → PN1.
  - QUES → PN1, with the digit source forced to "1".
  - PN1 → DEL (CPR, DA), else → FINAL.
  - DEL → PN2. For DA the digit source is forced to "0".
  - PN2 → FINAL.
  - CHAR and FINAL → IDLE.
  - Every non-IDLE transition occurs only on a byte transfer.
  - PN1 and PN2 remain in place until all digits of their value are transferred. A 2-bit digit index counts down from (digit count − 1) to 0.
- Arithmetic:
  - 8-bit binary to three BCD digits plus a digit count (1–3), computed combinationally from the latched value.
  - No overflow is possible since Pn ≤ 255.
- Reset mid-operation: the sequence in progress is aborted with no partial resume. The next accepted command starts from ESC (or CHAR).

## Timing
- Reset values: state = IDLE, cmdReady = 1, dataValid = 0, data = 8'h00, debug = 0, latched fields = 0.
- data and dataValid are registered.
- The first byte is valid the cycle after accept.
- With dataReady held high, one byte transfers per cycle with no gaps inside a sequence.
- data and dataValid are held stable while dataValid && !dataReady. No byte is dropped or duplicated.
- The final transfer at cycle t returns the FSM to IDLE at t+1. A command accepted at t+1 produces its first dataValid at t+2, giving exactly one empty cycle between back-to-back sequences.
- cmdValid while not IDLE has no effect; the command stays pending upstream.

## Configuration
- COMMANDS_ENCODER_OMIT_DEFAULT_EN:
  - Defined: for ENC_CUU/CUD/CUF/CUB with Pn1 == 1, the PN1 state is skipped and CSI goes straight to FINAL (e.g. 1B 5B 41). CPR and DA are unaffected.
  - Undefined: all parameters are always emitted.

## Structure
- The shared DataType package holds:
  - the EncCmd_t enum;
  - the EncState_t enum;
  - constants for ESC (8'h1B), '[' (8'h5B), ';' (8'h3B), '?' (8'h3F) and the final bytes.
- Sub-module dec_digits: combinational 8-bit to {hundreds, tens, units} BCD plus a 2-bit digit count. It is instantiated once and muxed between Pn1 and Pn2 by state.

## Test plan
- ENC_CHAR, Pchar = 41, dataReady = 1 → single byte 41 one cycle after accept; cmdReady high again the next cycle.
- ENC_CUF, Pn1 = 12, dataReady = 1 → 1B 5B 31 32 43 on 5 consecutive cycles.
- ENC_CPR, Pn1 = 24, Pn2 = 80 → 1B 5B 32 34 3B 38 30 52. ENC_DA → 1B 5B 3F 31 3B 30 63.
- ENC_CUB, Pn1 = 255, dataReady toggled pseudo-randomly → 1B 5B 32 35 35 44. data stays stable during stalls; exactly 6 transfers.
- ENC_CUU, Pn1 = 1 → 1B 5B 41 with the macro defined; 1B 5B 31 41 without. Pn1 = 0 → 1B 5B 30 41 in both builds.
- Assert rst after the 3rd byte of a CPR → dataValid = 0 and cmdReady = 1 immediately. A following ENC_CHAR 5A emits only 5A.
